// File: rtl/datapath_draft_if.sv
// Datapath-facing bundle: memory data/address, control strobes from the control FSM, observed outputs.
interface datapath_draft_if #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned REGBITS = 4
);
  logic [WIDTH-1:0]   memdata;
  logic               nextInstruction;
  logic               regWrite;
  logic               WriteData;
  logic               SrcB;
  logic               ZeroExtend;
  logic [REGBITS-1:0] ALUcond;
  logic               PSREN;
  logic               shiftType;
  logic [WIDTH-1:0]   shiftDir;
  logic [7:0]         shiftAmt;
  logic [1:0]         chooseResult;
  logic               resultEn;
  logic               StoreReg;
  logic               PCEN;
  logic               PCinstruction;
  logic               BranchEN;
  logic               jumpEN;
  logic               jalEN;
  logic               updateAddress;
  logic [WIDTH-1:0]   memOut;
  logic [WIDTH-1:0]   address;
  logic [7:0]         PSROut;

  // Control FSM / memory side
  modport master (
    output memdata, nextInstruction, regWrite, WriteData, SrcB, ZeroExtend, ALUcond,
           PSREN, shiftType, shiftDir, shiftAmt, chooseResult, resultEn, StoreReg,
           PCEN, PCinstruction, BranchEN, jumpEN, jalEN, updateAddress,
    input  memOut, address, PSROut
  );

  // Datapath side
  modport slave (
    input  memdata, nextInstruction, regWrite, WriteData, SrcB, ZeroExtend, ALUcond,
           PSREN, shiftType, shiftDir, shiftAmt, chooseResult, resultEn, StoreReg,
           PCEN, PCinstruction, BranchEN, jumpEN, jalEN, updateAddress,
    output memOut, address, PSROut
  );
endinterface

// File: rtl/datapath_draft.sv
// CR16-style 16-bit datapath: IR, 16-entry register file, ALU, shifter, immediate
// extender, result mux, PC with next-PC selection and a 5-flag PSR. Sequenced externally.
module datapath_draft #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned REGBITS = 4
) (
  input  logic           clk,
  input  logic           reset,
  datapath_draft_if.slave bus
);

  localparam int unsigned NREGS = 1 << REGBITS;
  localparam int unsigned IMMW  = 8;
  localparam int unsigned SHW   = 4;
  localparam int unsigned MSB   = WIDTH - 1;
  localparam int unsigned FLAGW = 5;

  localparam logic [REGBITS-1:0] OP_AND = REGBITS'(4'b0001);
  localparam logic [REGBITS-1:0] OP_OR  = REGBITS'(4'b0010);
  localparam logic [REGBITS-1:0] OP_XOR = REGBITS'(4'b0011);
  localparam logic [REGBITS-1:0] OP_ADD = REGBITS'(4'b0101);
  localparam logic [REGBITS-1:0] OP_SUB = REGBITS'(4'b1001);
  localparam logic [REGBITS-1:0] OP_CMP = REGBITS'(4'b1011);
  localparam logic [REGBITS-1:0] OP_MOV = REGBITS'(4'b1101);

  localparam logic [1:0] RES_SHIFT = 2'b00;
  localparam logic [1:0] RES_ALU   = 2'b01;
  localparam logic [1:0] RES_IMM   = 2'b10;
  localparam logic [1:0] RES_LINK  = 2'b11;

  // Architectural state
  logic [WIDTH-1:0] ir;
  logic [WIDTH-1:0] pc;
  logic [FLAGW-1:0] psr;
  logic [WIDTH-1:0] rf [NREGS];

  // Decoded fields and datapath nets
  logic [REGBITS-1:0] rdest;
  logic [REGBITS-1:0] rsrc;
  logic [IMMW-1:0]    imm;
  logic [WIDTH-1:0]   rd1;
  logic [WIDTH-1:0]   rd2;
  logic [WIDTH-1:0]   ext_imm;
  logic [WIDTH-1:0]   alu_b;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   flag_val;
  logic               flag_c;
  logic               flag_f;
  logic               flag_l;
  logic [FLAGW-1:0]   flags;
  logic [SHW-1:0]     sh_n;
  logic [WIDTH-1:0]   sh_res;
  logic [WIDTH-1:0]   pc_plus1;
  logic [WIDTH-1:0]   pc_next;
  logic [WIDTH-1:0]   result;
  logic [WIDTH-1:0]   wb_data;
  logic               unused_ok;

  // Reset contents of the register file
  function automatic logic [WIDTH-1:0] rf_init(input int unsigned idx);
    case (idx)
      1:       return WIDTH'(16'hFFFF);
      2, 10:   return WIDTH'(16'hAAAA);
      4:       return WIDTH'(16'hBBBB);
      default: return '0;
    endcase
  endfunction

  assign rdest = ir[IMMW +: REGBITS];
  assign rsrc  = ir[0 +: REGBITS];
  assign imm   = ir[IMMW-1:0];

  // Combinational register reads
  assign rd1 = rf[rdest];
  assign rd2 = rf[rsrc];

  // Immediate extension: zero- or sign-extend the low byte of IR
  assign ext_imm = bus.ZeroExtend ? {(WIDTH-IMMW)'(0), imm}
                                  : {{(WIDTH-IMMW){imm[IMMW-1]}}, imm};

  assign alu_b = bus.SrcB ? rd2 : ext_imm;
  assign sum   = {1'b0, rd1} + {1'b0, alu_b};
  assign diff  = {1'b0, rd1} - {1'b0, alu_b};

  // ALU result and arithmetic flags; CMP derives Z/N from the difference, not from its result
  always_comb begin
    alu_res  = alu_b;
    flag_val = alu_b;
    flag_c   = 1'b0;
    flag_f   = 1'b0;
    flag_l   = 1'b0;
    case (bus.ALUcond)
      OP_AND: begin
        alu_res  = rd1 & alu_b;
        flag_val = alu_res;
      end
      OP_OR: begin
        alu_res  = rd1 | alu_b;
        flag_val = alu_res;
      end
      OP_XOR: begin
        alu_res  = rd1 ^ alu_b;
        flag_val = alu_res;
      end
      OP_ADD: begin
        alu_res  = sum[WIDTH-1:0];
        flag_val = alu_res;
        flag_c   = sum[WIDTH];
        flag_f   = (rd1[MSB] == alu_b[MSB]) && (sum[MSB] != rd1[MSB]);
      end
      OP_SUB: begin
        alu_res  = diff[WIDTH-1:0];
        flag_val = alu_res;
        flag_c   = diff[WIDTH];
        flag_f   = (rd1[MSB] != alu_b[MSB]) && (diff[MSB] != rd1[MSB]);
      end
      OP_CMP: begin
        alu_res  = rd1;
        flag_val = diff[WIDTH-1:0];
        flag_c   = diff[WIDTH];
        flag_f   = (rd1[MSB] != alu_b[MSB]) && (diff[MSB] != rd1[MSB]);
        flag_l   = rd1 < alu_b;
      end
      OP_MOV: begin
        alu_res  = alu_b;
        flag_val = alu_res;
      end
      default: begin
        alu_res  = alu_b;
        flag_val = alu_res;
      end
    endcase
  end

  // PSR layout {L,C,F,N,Z}; upper three output bits are always zero
  assign flags = {flag_l, flag_c, flag_f, flag_val[MSB], (flag_val == '0)};

  // Shift count of zero is treated as one
  assign sh_n = (bus.shiftAmt[SHW-1:0] == '0) ? SHW'(1) : bus.shiftAmt[SHW-1:0];

  // Barrel shifter on rd1: left fills zeros, right fills zero or sign
  always_comb begin
    sh_res = rd1 << sh_n;
    if (bus.shiftDir[MSB]) begin
      if (bus.shiftType) sh_res = WIDTH'($signed(rd1) >>> sh_n);
      else               sh_res = rd1 >> sh_n;
    end
  end

  assign pc_plus1 = pc + WIDTH'(1);

  // Result select
  always_comb begin
    result = sh_res;
    case (bus.chooseResult)
      RES_SHIFT: result = sh_res;
      RES_ALU:   result = alu_res;
      RES_IMM:   result = ext_imm;
      RES_LINK:  result = pc_plus1;
      default:   result = sh_res;
    endcase
  end

  // Next-PC select: register jump beats branch beats sequential
  always_comb begin
    pc_next = pc_plus1;
    if (bus.jalEN || bus.jumpEN) pc_next = rd2;
    else if (bus.BranchEN)       pc_next = pc + ext_imm;
    else if (bus.PCinstruction)  pc_next = pc_plus1;
  end

  assign wb_data = bus.WriteData ? result : bus.memdata;

  // Instruction register
  always_ff @(posedge clk) begin
    if (reset)                    ir <= '0;
    else if (bus.nextInstruction) ir <= bus.memdata;
  end

  // Program counter
  always_ff @(posedge clk) begin
    if (reset)         pc <= '0;
    else if (bus.PCEN) pc <= pc_next;
  end

  // Processor status register
  always_ff @(posedge clk) begin
    if (reset)          psr <= '0;
    else if (bus.PSREN) psr <= flags;
  end

  // Register file with preset contents; R0 is an ordinary writable register
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) rf[i] <= rf_init(i);
    end else if (bus.regWrite) begin
      rf[rdest] <= wb_data;
    end
  end

  assign bus.memOut  = bus.StoreReg ? rd1 : (bus.resultEn ? result : '0);
  assign bus.address = bus.updateAddress ? pc : rd2;
  assign bus.PSROut  = {(8-FLAGW)'(0), psr};

  // Opcode nibble and unused control bits are not consumed by the datapath
  assign unused_ok = ^{ir[WIDTH-1:IMMW+REGBITS], bus.shiftDir[MSB-1:0], bus.shiftAmt[7:SHW]};

endmodule

// File: tb/tb_datapath_draft.sv
// Scoreboard bench for datapath_draft: stimulus queues expected values, negedge monitor compares.
module tb_datapath_draft;

  logic clk;
  logic reset;

  datapath_draft_if #(.WIDTH(16), .REGBITS(4)) bus ();

  datapath_draft #(.WIDTH(16), .REGBITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam int SEL_OUT  = 0;
  localparam int SEL_ADDR = 1;
  localparam int SEL_PSR  = 2;

  string       q_name [$];
  int          q_sel  [$];
  logic [15:0] q_exp  [$];

  int n_vec  = 0;
  int n_miss = 0;

  // ALU vectors: IR, ALUcond, SrcB, ZeroExtend, memOut, PSR after the PSREN edge
  logic [15:0] a_ir   [12] = '{16'h0222, 16'h0224, 16'h0224, 16'h0224, 16'h022A, 16'h0224,
                               16'h0224, 16'h0224, 16'h0224, 16'h01FF, 16'h01FF, 16'h0101};
  logic [3:0]  a_cond [12] = '{4'h5, 4'h9, 4'hB, 4'h3, 4'h3, 4'h1,
                               4'h2, 4'hD, 4'h0, 4'h5, 4'h5, 4'h5};
  logic        a_srcb [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                               1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic        a_zx   [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [15:0] a_out  [12] = '{16'h5554, 16'hEEEF, 16'hAAAA, 16'h1111, 16'h0000, 16'hAAAA,
                               16'hBBBB, 16'hBBBB, 16'hBBBB, 16'hFFFE, 16'h00FE, 16'h0000};
  logic [7:0]  a_psr  [12] = '{8'h0C, 8'h0A, 8'h1A, 8'h00, 8'h01, 8'h02,
                               8'h02, 8'h02, 8'h02, 8'h0A, 8'h08, 8'h09};

  // Shifter vectors on R10=AAAA: shiftDir, shiftAmt, shiftType, resultEn, memOut
  logic [15:0] s_dir  [9] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h8000,
                              16'h0000, 16'h7FFF, 16'h0000, 16'h0000};
  logic [7:0]  s_amt  [9] = '{8'h00, 8'h00, 8'h0F, 8'h0F, 8'h34, 8'h04, 8'h01, 8'h0F, 8'h04};
  logic        s_typ  [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic        s_en   [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [15:0] s_exp  [9] = '{16'h5555, 16'hD555, 16'hFFFF, 16'h0001, 16'h0AAA,
                              16'hAAA0, 16'h5554, 16'h0000, 16'h0000};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every falling edge, compare each queued expectation against the live outputs
  always @(negedge clk) begin
    while (q_exp.size() != 0) begin : drain
      string       nm;
      int          sel;
      logic [15:0] ex;
      logic [15:0] act;
      nm  = q_name.pop_front();
      sel = q_sel.pop_front();
      ex  = q_exp.pop_front();
      if (sel == SEL_OUT)       act = bus.memOut;
      else if (sel == SEL_ADDR) act = bus.address;
      else                      act = {8'h00, bus.PSROut};
      n_vec++;
      if (act !== ex) begin
        n_miss++;
        $display("FAIL %s: got %h, expected %h", nm, act, ex);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_now();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_val(input string nm, input int sel, input logic [15:0] v);
    q_name.push_back(nm);
    q_sel.push_back(sel);
    q_exp.push_back(v);
  endtask

  task automatic clear_ctl();
    bus.memdata         = 16'h0000;
    bus.nextInstruction = 1'b0;
    bus.regWrite        = 1'b0;
    bus.WriteData       = 1'b0;
    bus.SrcB            = 1'b0;
    bus.ZeroExtend      = 1'b0;
    bus.ALUcond         = 4'h0;
    bus.PSREN           = 1'b0;
    bus.shiftType       = 1'b0;
    bus.shiftDir        = 16'h0000;
    bus.shiftAmt        = 8'h00;
    bus.chooseResult    = 2'b00;
    bus.resultEn        = 1'b0;
    bus.StoreReg        = 1'b0;
    bus.PCEN            = 1'b0;
    bus.PCinstruction   = 1'b0;
    bus.BranchEN        = 1'b0;
    bus.jumpEN          = 1'b0;
    bus.jalEN           = 1'b0;
    bus.updateAddress   = 1'b1;
  endtask

  task automatic do_reset();
    clear_ctl();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load_ir(input logic [15:0] v);
    bus.memdata         = v;
    bus.nextInstruction = 1'b1;
    tick();
    bus.nextInstruction = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_ctl();

    // Reset wins over every enable active on the same edge
    bus.PCEN            = 1'b1;
    bus.PCinstruction   = 1'b1;
    bus.nextInstruction = 1'b1;
    bus.memdata         = 16'h1234;
    bus.PSREN           = 1'b1;
    bus.regWrite        = 1'b1;
    tick();
    reset = 1'b0;
    clear_ctl();
    bus.chooseResult = 2'b10;
    bus.resultEn     = 1'b1;
    #1;
    if (bus.address !== 16'h0000) begin
      n_miss++;
      $display("FAIL reset_address_direct: got %h, expected 0000", bus.address);
    end
    expect_val("reset_address", SEL_ADDR, 16'h0000);
    expect_val("reset_psr", SEL_PSR, 16'h0000);
    expect_val("reset_ir_imm", SEL_OUT, 16'h0000);
    check_now();

    // ADD R1,R2 with writeback and PSR load
    clear_ctl();
    bus.memdata         = 16'h0152;
    bus.nextInstruction = 1'b1;
    bus.SrcB            = 1'b1;
    bus.ALUcond         = 4'h5;
    bus.chooseResult    = 2'b01;
    bus.resultEn        = 1'b1;
    bus.PSREN           = 1'b1;
    bus.regWrite        = 1'b1;
    bus.WriteData       = 1'b1;
    tick();
    expect_val("add_memout_edge1", SEL_OUT, 16'hAAA9);
    expect_val("add_psr_edge1", SEL_PSR, 16'h0001);
    check_now();
    bus.nextInstruction = 1'b0;
    tick();
    expect_val("add_psr_edge2", SEL_PSR, 16'h000A);
    bus.regWrite = 1'b0;
    bus.PSREN    = 1'b0;
    bus.StoreReg = 1'b1;
    expect_val("add_r1_writeback", SEL_OUT, 16'hAAA9);
    check_now();

    // Sequential PC stepping and hold
    clear_ctl();
    bus.PCEN          = 1'b1;
    bus.PCinstruction = 1'b1;
    tick();
    expect_val("pc_inc", SEL_ADDR, 16'h0001);
    check_now();
    bus.PCinstruction = 1'b0;
    tick();
    expect_val("pc_default_inc", SEL_ADDR, 16'h0002);
    check_now();
    bus.PCEN = 1'b0;
    tick();
    expect_val("pc_hold", SEL_ADDR, 16'h0002);
    check_now();
    bus.updateAddress = 1'b0;
    expect_val("address_rsrc", SEL_ADDR, 16'hAAAA);
    check_now();

    // Branch with sign-extended offset
    do_reset();
    load_ir(16'h0182);
    bus.BranchEN = 1'b1;
    bus.PCEN     = 1'b1;
    tick();
    expect_val("branch_sext", SEL_ADDR, 16'hFF82);
    check_now();

    // Branch with zero-extended offset; immediate on the result path
    do_reset();
    load_ir(16'h0182);
    bus.ZeroExtend   = 1'b1;
    bus.chooseResult = 2'b10;
    bus.resultEn     = 1'b1;
    bus.BranchEN     = 1'b1;
    bus.PCEN         = 1'b1;
    expect_val("imm_zext_memout", SEL_OUT, 16'h0082);
    check_now();
    tick();
    expect_val("branch_zext", SEL_ADDR, 16'h0082);
    check_now();

    // JAL: link value from current PC; register target beats branch and increment
    do_reset();
    load_ir(16'h0384);
    bus.jalEN         = 1'b1;
    bus.BranchEN      = 1'b1;
    bus.PCinstruction = 1'b1;
    bus.PCEN          = 1'b1;
    bus.chooseResult  = 2'b11;
    bus.resultEn      = 1'b1;
    expect_val("jal_link", SEL_OUT, 16'h0001);
    check_now();
    tick();
    expect_val("jal_target", SEL_ADDR, 16'hBBBB);
    check_now();

    // StoreReg path shows R[Rdest]
    do_reset();
    load_ir(16'h0484);
    bus.StoreReg = 1'b1;
    #1;
    if (bus.memOut !== 16'hBBBB) begin
      n_miss++;
      $display("FAIL storereg_direct: got %h, expected BBBB", bus.memOut);
    end
    expect_val("storereg_r4", SEL_OUT, 16'hBBBB);
    check_now();

    // Load from memory into R11
    clear_ctl();
    load_ir(16'hFBAF);
    bus.regWrite  = 1'b1;
    bus.WriteData = 1'b0;
    tick();
    bus.regWrite = 1'b0;
    bus.StoreReg = 1'b1;
    expect_val("load_r11", SEL_OUT, 16'hFBAF);
    check_now();
    bus.updateAddress = 1'b0;
    expect_val("address_r15", SEL_ADDR, 16'h0000);
    check_now();

    // ALU operations and flags
    do_reset();
    for (int i = 0; i < 12; i++) begin
      load_ir(a_ir[i]);
      bus.SrcB         = a_srcb[i];
      bus.ZeroExtend   = a_zx[i];
      bus.ALUcond      = a_cond[i];
      bus.chooseResult = 2'b01;
      bus.resultEn     = 1'b1;
      bus.StoreReg     = 1'b0;
      bus.PSREN        = 1'b1;
      expect_val($sformatf("alu%0d_result", i), SEL_OUT, a_out[i]);
      check_now();
      tick();
      bus.PSREN = 1'b0;
      expect_val($sformatf("alu%0d_psr", i), SEL_PSR, {8'h00, a_psr[i]});
      check_now();
    end

    // Shifter on R10
    do_reset();
    load_ir(16'hAAAA);
    bus.chooseResult = 2'b00;
    bus.StoreReg     = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus.shiftDir  = s_dir[i];
      bus.shiftAmt  = s_amt[i];
      bus.shiftType = s_typ[i];
      bus.resultEn  = s_en[i];
      expect_val($sformatf("shift%0d", i), SEL_OUT, s_exp[i]);
      check_now();
    end

    tick();
    check_now();
    if (n_vec != 52) begin
      n_miss++;
      $display("FAIL vector_count: got %0d, expected 52", n_vec);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    if (n_miss == 0) $display("PASS");
    else             $display("FAIL %0d miscompares", n_miss);
    $finish;
  end

endmodule
